pc_unit: RTL and testbench

Program-counter register and PC write-enable stage of the multicycle core. It sits directly downstream of the PC-source mux: it consumes the selected next-PC value and evaluates the branch condition to decide whether PC is written. It also captures EPC on exceptions and runs the exception-vector fetch, which loads PC from the handler byte at memory address 253 + code. It drives the current PC to instruction fetch and the EPC value back to the mux.

---
 rtl/pc_unit.sv | 101 ++++++++++
 tb/tb_pc_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter register, branch write-enable and exception-vector fetch
module pc_unit #(
  parameter logic [31:0] VEC_BASE = 32'd253,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_source_in,
  input  logic        pc_write,
  input  logic        pc_write_cond,
  input  logic [1:0]  branch_op,
  input  logic        alu_zero,
  input  logic        alu_gt,
  input  logic        exc_valid,
  input  logic [1:0]  exc_code,
  output logic        vec_mem_req,
  output logic [31:0] vec_mem_addr,
  input  logic        vec_mem_ack,
  input  logic [7:0]  vec_mem_data,
  output logic        exc_busy,
  output logic [31:0] pc_out,
  output logic [31:0] epc_out
);

  typedef enum logic {IDLE, VFETCH} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic [1:0]  code_q, code_d;
  logic        cond;
  logic        exc_accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      epc_q   <= 32'd0;
      code_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    cond = 1'b0;
    case (branch_op)
      2'b00: cond = alu_zero;
      2'b01: cond = ~alu_zero;
      2'b10: cond = alu_gt;
      2'b11: cond = ~alu_gt;
      default: cond = 1'b0;
    endcase
  end

  // Code 3 is reserved and never starts an exception entry.
  assign exc_accept = (state_q == IDLE) && exc_valid && (exc_code != 2'd3);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    code_d  = code_q;
    case (state_q)
      IDLE: begin
        if (exc_accept) begin
          epc_d   = pc_q - 32'd4;
          code_d  = exc_code;
          state_d = VFETCH;
        end else if (pc_write || (pc_write_cond && cond)) begin
          pc_d = pc_source_in;
        end
      end
      VFETCH: begin
        if (vec_mem_ack) begin
          pc_d    = {24'b0, vec_mem_data};
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    vec_mem_req  = 1'b0;
    vec_mem_addr = 32'd0;
    exc_busy     = 1'b0;
    if (state_q == VFETCH) begin
      vec_mem_req  = 1'b1;
      vec_mem_addr = VEC_BASE + 32'(code_q);
      exc_busy     = 1'b1;
    end
  end

  assign pc_out  = pc_q;
  assign epc_out = epc_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - self-checking bench for pc_unit against a behavioural model
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_source_in;
  logic        pc_write, pc_write_cond;
  logic [1:0]  branch_op;
  logic        alu_zero, alu_gt;
  logic        exc_valid;
  logic [1:0]  exc_code;
  logic        vec_mem_req;
  logic [31:0] vec_mem_addr;
  logic        vec_mem_ack;
  logic [7:0]  vec_mem_data;
  logic        exc_busy;
  logic [31:0] pc_out, epc_out;

  int checks = 0;
  int failures = 0;

  // Behavioural model: architectural PC/EPC plus "waiting for vector byte of code m_code".
  logic [31:0] m_pc, m_epc;
  bit          m_busy;
  int          m_code;

  pc_unit dut (
    .clk(clk), .reset(reset), .pc_source_in(pc_source_in), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .branch_op(branch_op), .alu_zero(alu_zero),
    .alu_gt(alu_gt), .exc_valid(exc_valid), .exc_code(exc_code),
    .vec_mem_req(vec_mem_req), .vec_mem_addr(vec_mem_addr), .vec_mem_ack(vec_mem_ack),
    .vec_mem_data(vec_mem_data), .exc_busy(exc_busy), .pc_out(pc_out), .epc_out(epc_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit branch_taken(input logic [1:0] op, input logic z, input logic g);
    case (op)
      2'b00: return z;
      2'b01: return !z;
      2'b10: return g;
      default: return !g;
    endcase
  endfunction

  function automatic logic [31:0] m_addr();
    return m_busy ? (32'd253 + 32'(m_code)) : 32'd0;
  endfunction

  task automatic model_reset();
    m_pc = 32'd0; m_epc = 32'd0; m_busy = 0; m_code = 0;
  endtask

  task automatic idle_inputs();
    pc_source_in = 32'd0; pc_write = 0; pc_write_cond = 0; branch_op = 2'b00;
    alu_zero = 0; alu_gt = 0; exc_valid = 0; exc_code = 2'd0;
    vec_mem_ack = 0; vec_mem_data = 8'd0;
  endtask

  // Advance one clock: update the model from the applied inputs, then sample #1 after the edge.
  task automatic step();
    if (m_busy) begin
      if (vec_mem_ack) begin
        m_pc = {24'd0, vec_mem_data};
        m_busy = 0;
      end
    end else if (exc_valid && exc_code != 2'd3) begin
      m_epc = m_pc - 32'd4;
      m_code = int'(exc_code);
      m_busy = 1;
    end else if (pc_write || (pc_write_cond && branch_taken(branch_op, alu_zero, alu_gt))) begin
      m_pc = pc_source_in;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_pc(input logic [31:0] v);
    idle_inputs();
    pc_source_in = v; pc_write = 1;
    step();
    idle_inputs();
  endtask

  task automatic test_reset();
    checks++; if (pc_out !== 32'd0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc_out, 32'd0); end
    checks++; if (epc_out !== 32'd0) begin failures++; $display("FAIL reset_epc got=%h exp=%h", epc_out, 32'd0); end
    checks++; if (vec_mem_req !== 1'b0 || exc_busy !== 1'b0) begin failures++; $display("FAIL reset_req_busy got=%b%b exp=00", vec_mem_req, exc_busy); end
    checks++; if (vec_mem_addr !== 32'd0) begin failures++; $display("FAIL reset_addr got=%h exp=%h", vec_mem_addr, 32'd0); end
    @(posedge clk); #1;
    reset = 0;
    model_reset();
  endtask

  task automatic test_uncond_write();
    load_pc(32'h40);
    checks++; if (pc_out !== 32'h40) begin failures++; $display("FAIL uncond_write got=%h exp=%h", pc_out, 32'h40); end
    pc_source_in = 32'h1234_5678;
    step();
    checks++; if (pc_out !== 32'h40) begin failures++; $display("FAIL uncond_hold got=%h exp=%h", pc_out, 32'h40); end
  endtask

  task automatic test_branch();
    logic [31:0] base, exp;
    for (int i = 0; i < 4; i++) begin
      base = 32'h50 + 32'(i * 4);
      load_pc(base);
      pc_source_in = 32'h100; pc_write_cond = 1; branch_op = 2'(i);
      alu_zero = (i < 2); alu_gt = (i >= 2);
      exp = (i == 0 || i == 2) ? 32'h100 : base;
      step();
      checks++; if (pc_out !== exp) begin failures++; $display("FAIL branch_op%0d got=%h exp=%h", i, pc_out, exp); end
      idle_inputs();
    end
  endtask

  task automatic test_exception();
    load_pc(32'h24);
    exc_valid = 1; exc_code = 2'd1; pc_write = 1; pc_source_in = 32'h999;
    step();
    idle_inputs();
    checks++; if (epc_out !== 32'h20) begin failures++; $display("FAIL exc_epc got=%h exp=%h", epc_out, 32'h20); end
    checks++; if (pc_out !== 32'h24) begin failures++; $display("FAIL exc_pc_hold got=%h exp=%h", pc_out, 32'h24); end
    checks++; if (vec_mem_addr !== 32'd254 || exc_busy !== 1'b1 || vec_mem_req !== 1'b1) begin
      failures++; $display("FAIL exc_vfetch got addr=%0d busy=%b req=%b exp addr=254 busy=1 req=1", vec_mem_addr, exc_busy, vec_mem_req); end
    for (int w = 0; w < 3; w++) step();
    checks++; if (exc_busy !== 1'b1 || vec_mem_addr !== 32'd254) begin failures++; $display("FAIL exc_wait got busy=%b addr=%0d exp busy=1 addr=254", exc_busy, vec_mem_addr); end
    vec_mem_ack = 1; vec_mem_data = 8'hA5;
    step();
    idle_inputs();
    checks++; if (pc_out !== 32'hA5) begin failures++; $display("FAIL exc_vector_pc got=%h exp=%h", pc_out, 32'hA5); end
    checks++; if (exc_busy !== 1'b0 || vec_mem_req !== 1'b0 || vec_mem_addr !== 32'd0) begin
      failures++; $display("FAIL exc_return_idle got busy=%b req=%b addr=%h exp 0 0 0", exc_busy, vec_mem_req, vec_mem_addr); end
  endtask

  task automatic test_busy_lockout();
    load_pc(32'h300);
    exc_valid = 1; exc_code = 2'd1;
    step();
    idle_inputs();
    exc_valid = 1; exc_code = 2'd2; pc_write = 1; pc_write_cond = 1; pc_source_in = 32'h777;
    step(); step();
    checks++; if (epc_out !== 32'h2FC || pc_out !== 32'h300) begin failures++; $display("FAIL lockout got epc=%h pc=%h exp epc=2fc pc=300", epc_out, pc_out); end
    checks++; if (vec_mem_addr !== 32'd254) begin failures++; $display("FAIL lockout_addr got=%0d exp=254", vec_mem_addr); end
    idle_inputs();
    vec_mem_ack = 1; vec_mem_data = 8'h3C;
    step();
    idle_inputs();
    checks++; if (pc_out !== 32'h3C || exc_busy !== 1'b0) begin failures++; $display("FAIL lockout_ack got pc=%h busy=%b exp pc=3c busy=0", pc_out, exc_busy); end
  endtask

  task automatic test_code3();
    logic [31:0] epc_before;
    epc_before = m_epc;
    exc_valid = 1; exc_code = 2'd3; pc_write = 1; pc_source_in = 32'h88;
    step();
    idle_inputs();
    checks++; if (pc_out !== 32'h88 || exc_busy !== 1'b0) begin failures++; $display("FAIL code3 got pc=%h busy=%b exp pc=88 busy=0", pc_out, exc_busy); end
    checks++; if (epc_out !== epc_before) begin failures++; $display("FAIL code3_epc got=%h exp=%h", epc_out, epc_before); end
  endtask

  task automatic test_ack_idle();
    vec_mem_ack = 1; vec_mem_data = 8'hFF;
    step();
    idle_inputs();
    checks++; if (pc_out !== 32'h88) begin failures++; $display("FAIL ack_idle got=%h exp=%h", pc_out, 32'h88); end
  endtask

  task automatic test_exc_at_zero();
    load_pc(32'h0);
    exc_valid = 1; exc_code = 2'd2;
    step();
    idle_inputs();
    checks++; if (epc_out !== 32'hFFFF_FFFC) begin failures++; $display("FAIL exc_zero_epc got=%h exp=fffffffc", epc_out); end
    checks++; if (vec_mem_addr !== 32'd255) begin failures++; $display("FAIL exc_zero_addr got=%0d exp=255", vec_mem_addr); end
    vec_mem_ack = 1; vec_mem_data = 8'h10;
    step();
    idle_inputs();
    checks++; if (pc_out !== 32'h10) begin failures++; $display("FAIL exc_zero_vec got=%h exp=10", pc_out); end
  endtask

  task automatic test_reset_mid_vfetch();
    load_pc(32'h44);
    exc_valid = 1; exc_code = 2'd0;
    step();
    idle_inputs();
    #3 reset = 1;
    #1;
    checks++; if (pc_out !== 32'd0 || epc_out !== 32'd0) begin failures++; $display("FAIL reset_vfetch got pc=%h epc=%h exp 0 0", pc_out, epc_out); end
    checks++; if (vec_mem_req !== 1'b0 || exc_busy !== 1'b0) begin failures++; $display("FAIL reset_vfetch_req got req=%b busy=%b exp 0 0", vec_mem_req, exc_busy); end
    @(posedge clk); #1;
    reset = 0;
    model_reset();
    load_pc(32'h8);
    checks++; if (pc_out !== 32'h8) begin failures++; $display("FAIL reset_release_write got=%h exp=8", pc_out); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      pc_source_in  = $urandom;
      pc_write      = ($urandom_range(0, 2) == 0);
      pc_write_cond = $urandom_range(0, 1);
      branch_op     = 2'($urandom_range(0, 3));
      alu_zero      = $urandom_range(0, 1);
      alu_gt        = $urandom_range(0, 1);
      exc_valid     = ($urandom_range(0, 5) == 0);
      exc_code      = 2'($urandom_range(0, 3));
      vec_mem_ack   = ($urandom_range(0, 2) == 0);
      vec_mem_data  = 8'($urandom);
      step();
      checks++;
      if (pc_out !== m_pc || epc_out !== m_epc || exc_busy !== m_busy ||
          vec_mem_req !== m_busy || vec_mem_addr !== m_addr()) begin
        failures++;
        $display("FAIL random_%0d got pc=%h epc=%h busy=%b req=%b addr=%h exp pc=%h epc=%h busy=%b addr=%h",
                 n, pc_out, epc_out, exc_busy, vec_mem_req, vec_mem_addr, m_pc, m_epc, m_busy, m_addr());
      end
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_uncond_write();
    test_branch();
    test_exception();
    test_busy_lockout();
    test_code3();
    test_ack_idle();
    test_exc_at_zero();
    test_reset_mid_vfetch();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
